// File: rtl/io_pkg.sv
// Shared definitions for the buffered byte/word I/O unit.
package io_pkg;

  localparam int unsigned OPE_IN_BIT   = 3;
  localparam int unsigned OPE_WORD_BIT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } io_state_e;

endpackage

// File: rtl/io_byte_fifo.sv
// 8-bit synchronous FIFO; push into a full FIFO or pop from an empty one is dropped.
module io_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gated so the head reads zero out of reset even though storage is not cleared.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_buffered.sv
// Buffered IN/OUT unit: byte or 4-byte little-endian ops against RX/TX FIFOs,
// with IN results written back to the register file.
module io_buffered
  import io_pkg::*;
#(
  parameter  int unsigned RX_DEPTH = 16,
  parameter  int unsigned TX_DEPTH = 16,
  localparam int unsigned LVL_W    = $clog2(RX_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       ope,
  input  logic [31:0]      ds_val,
  input  logic [5:0]       dd,
  output logic [5:0]       reg_addr,
  output logic [31:0]      reg_dd_val,
  output logic             io_busy,
  input  logic [7:0]       io_in_data,
  input  logic             io_in_vld,
  output logic             io_in_rdy,
  output logic [7:0]       io_out_data,
  output logic             io_out_vld,
  input  logic             io_out_rdy,
  output logic [LVL_W-1:0] rx_level
);

  logic                        rx_full, rx_empty, rx_pop;
  logic [7:0]                  rx_head;
  logic                        tx_full, tx_empty, tx_push;
  logic [7:0]                  tx_din;
  logic [$clog2(TX_DEPTH):0]   tx_count_unused;

  io_state_e   state_q, state_d;
  logic        is_in_q, is_in_d;
  logic [1:0]  rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic [5:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_dd_val_q, reg_dd_val_d;
  logic [31:0] word;

  io_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk   (clk),
    .rstn  (rstn),
    .push  (io_in_vld),
    .din   (io_in_data),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_level),
    .head  (rx_head)
  );

  io_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (io_out_rdy),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused),
    .head  (io_out_data)
  );

  assign io_in_rdy  = !rx_full;
  assign io_out_vld = !tx_empty;
  assign tx_din     = data_q[{idx_q, 3'b000} +: 8];
  assign io_busy    = busy_q;
  assign reg_addr   = reg_addr_q;
  assign reg_dd_val = reg_dd_val_q;

  always_comb begin
    state_d      = state_q;
    is_in_d      = is_in_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    data_d       = data_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    reg_addr_d   = '0;
    reg_dd_val_d = reg_dd_val_q;
    tx_push      = 1'b0;
    rx_pop       = 1'b0;
    word         = data_q;
    case (state_q)
      IDLE: begin
        if (ope != '0) begin
          is_in_d = ope[OPE_IN_BIT];
          rem_d   = ope[OPE_WORD_BIT] ? 2'd3 : 2'd0;
          data_d  = ds_val;
          addr_d  = dd;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!is_in_q) begin
          if (!tx_full) begin
            tx_push = 1'b1;
            idx_d   = idx_q + 2'd1;
            if (idx_q == rem_q) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end else if (!rx_empty) begin
          rx_pop = 1'b1;
          // First popped byte clears the latched operand so upper lanes read zero.
          word   = (idx_q == 2'd0) ? '0 : data_q;
          word[{idx_q, 3'b000} +: 8] = rx_head;
          data_d = word;
          idx_d  = idx_q + 2'd1;
          if (idx_q == rem_q) begin
            reg_addr_d   = addr_q;
            reg_dd_val_d = word;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      is_in_q      <= 1'b0;
      rem_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      reg_addr_q   <= '0;
      reg_dd_val_q <= '0;
    end else begin
      state_q      <= state_d;
      is_in_q      <= is_in_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      reg_addr_q   <= reg_addr_d;
      reg_dd_val_q <= reg_dd_val_d;
    end
  end

endmodule

// File: tb/tb_io_buffered.sv
// Scenario bench for io_buffered; TX bytes and writebacks are checked against scoreboards.
module tb_io_buffered;

  localparam int unsigned RXD = 16;
  localparam int unsigned TXD = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  ope;
  logic [31:0] ds_val;
  logic [5:0]  dd;
  logic [5:0]  reg_addr;
  logic [31:0] reg_dd_val;
  logic        io_busy;
  logic [7:0]  io_in_data;
  logic        io_in_vld;
  logic        io_in_rdy;
  logic [7:0]  io_out_data;
  logic        io_out_vld;
  logic        io_out_rdy;
  logic [$clog2(RXD):0] rx_level;

  io_buffered #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ope         (ope),
    .ds_val      (ds_val),
    .dd          (dd),
    .reg_addr    (reg_addr),
    .reg_dd_val  (reg_dd_val),
    .io_busy     (io_busy),
    .io_in_data  (io_in_data),
    .io_in_vld   (io_in_vld),
    .io_in_rdy   (io_in_rdy),
    .io_out_data (io_out_data),
    .io_out_vld  (io_out_vld),
    .io_out_rdy  (io_out_rdy),
    .rx_level    (rx_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wb_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  txq[$];
  wb_t         wbq[$];
  logic [7:0]  exp_b;
  wb_t         exp_w;

  // Scoreboard monitor: every accepted TX byte and every writeback must match the queue head.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (io_out_vld && io_out_rdy) begin
        n_cmp++;
        if (txq.size() == 0) begin
          n_bad++;
          $display("FAIL tx_byte: got %02h, expected no byte", io_out_data);
        end else begin
          exp_b = txq.pop_front();
          if (io_out_data !== exp_b) begin
            n_bad++;
            $display("FAIL tx_byte: got %02h, expected %02h", io_out_data, exp_b);
          end
        end
      end
      if (reg_addr !== 6'd0) begin
        n_cmp++;
        if (wbq.size() == 0) begin
          n_bad++;
          $display("FAIL writeback: got r%0d=%08h, expected none", reg_addr, reg_dd_val);
        end else begin
          exp_w = wbq.pop_front();
          if (reg_addr !== exp_w.a || reg_dd_val !== exp_w.d) begin
            n_bad++;
            $display("FAIL writeback: got r%0d=%08h, expected r%0d=%08h",
                     reg_addr, reg_dd_val, exp_w.a, exp_w.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] v, input logic [5:0] d);
    ope = o; ds_val = v; dd = d;
    tick();
    ope = '0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    io_in_data = b; io_in_vld = 1'b1;
    tick();
    io_in_vld = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max, output bit ok);
    int unsigned n = 0;
    while (io_busy && n < max) begin
      tick();
      n++;
    end
    ok = !io_busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ope = '0; ds_val = '0; dd = '0;
    io_in_data = '0; io_in_vld = 1'b0; io_out_rdy = 1'b0;
    #1;
    n_cmp++;
    if ({reg_addr, reg_dd_val, io_busy, io_in_rdy, io_out_vld, io_out_data, rx_level} !==
        {6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL reset_state: addr=%0d val=%08h busy=%b irdy=%b ovld=%b odata=%02h lvl=%0d, expected 0/0/0/1/0/00/0",
               reg_addr, reg_dd_val, io_busy, io_in_rdy, io_out_vld, io_out_data, rx_level);
    end
    repeat (3) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_out_byte();
    io_out_rdy = 1'b1;
    txq.push_back(8'hA5);
    issue(6'h01, 32'h1234_56A5, 6'd0);
    n_cmp++;
    if (io_busy !== 1'b1 || io_out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL out_byte_n1: busy=%b vld=%b, expected 1/0", io_busy, io_out_vld);
    end
    tick();
    n_cmp++;
    if (io_busy !== 1'b0 || io_out_vld !== 1'b1 || io_out_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL out_byte_n2: busy=%b vld=%b data=%02h, expected 0/1/a5", io_busy, io_out_vld, io_out_data);
    end
    tick();
    n_cmp++;
    if (io_out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL out_byte_n3: vld=%b, expected 0", io_out_vld);
    end
  endtask

  task automatic test_in_word();
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33); rx_push(8'h44);
    n_cmp++;
    if (rx_level !== 5'd4) begin
      n_bad++;
      $display("FAIL in_word_level: got %0d, expected 4", rx_level);
    end
    wbq.push_back('{a: 6'd5, d: 32'h4433_2211});
    issue(6'h18, 32'hFFFF_FFFF, 6'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (io_busy !== 1'b1 || reg_addr !== 6'd0) begin
        n_bad++;
        $display("FAIL in_word_busy: cycle N+%0d busy=%b addr=%0d, expected 1/0", i + 2, io_busy, reg_addr);
      end
    end
    tick();
    n_cmp++;
    if (io_busy !== 1'b0 || reg_addr !== 6'd5 || reg_dd_val !== 32'h4433_2211 || rx_level !== 5'd0) begin
      n_bad++;
      $display("FAIL in_word_wb: busy=%b addr=%0d val=%08h lvl=%0d, expected 0/5/44332211/0",
               io_busy, reg_addr, reg_dd_val, rx_level);
    end
    tick();
    n_cmp++;
    if (reg_addr !== 6'd0 || reg_dd_val !== 32'h4433_2211) begin
      n_bad++;
      $display("FAIL in_word_after: addr=%0d val=%08h, expected 0/44332211", reg_addr, reg_dd_val);
    end
  endtask

  task automatic test_in_stall();
    int unsigned drops = 0;
    bit ok;
    wbq.push_back('{a: 6'd7, d: 32'h0000_009C});
    issue(6'h08, 32'hDEAD_BEEF, 6'd7);
    repeat (10) begin
      if (io_busy !== 1'b1) drops++;
      tick();
    end
    n_cmp++;
    if (drops != 0) begin
      n_bad++;
      $display("FAIL in_stall_hold: busy low in %0d cycles, expected 0", drops);
    end
    rx_push(8'h9C);
    wait_idle(5, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL in_stall_release: busy=%b, expected 0", io_busy);
    end
    tick();
    n_cmp++;
    if (wbq.size() != 0 || rx_level !== 5'd0) begin
      n_bad++;
      $display("FAIL in_stall_wb: pending=%0d lvl=%0d, expected 0/0", wbq.size(), rx_level);
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] w;
    bit ok;
    int unsigned drops = 0;
    int unsigned n = 0;
    io_out_rdy = 1'b0;
    for (int k = 0; k < int'(TXD / 4); k++) begin
      w = 32'h0403_0201 + 32'(k) * 32'h0404_0404;
      for (int b = 0; b < 4; b++) txq.push_back(w[8*b +: 8]);
      issue(6'h10, w, 6'd0);
      wait_idle(10, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL tx_fill_op%0d: busy=%b, expected 0", k, io_busy);
      end
    end
    w = 32'hDDCC_BBAA;
    for (int b = 0; b < 4; b++) txq.push_back(w[8*b +: 8]);
    issue(6'h10, w, 6'd0);
    repeat (8) begin
      if (io_busy !== 1'b1) drops++;
      tick();
    end
    n_cmp++;
    if (drops != 0 || io_out_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_full_stall: busy-low cycles=%0d vld=%b, expected 0/1", drops, io_out_vld);
    end
    io_out_rdy = 1'b1;
    while ((txq.size() != 0 || io_out_vld) && n < 60) begin
      tick();
      n++;
    end
    n_cmp++;
    if (txq.size() != 0 || io_out_vld !== 1'b0 || io_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_drain: left=%0d vld=%b busy=%b, expected 0/0/0", txq.size(), io_out_vld, io_busy);
    end
  endtask

  task automatic test_rx_full();
    io_in_vld = 1'b1;
    for (int i = 0; i < int'(RXD); i++) begin
      io_in_data = 8'h50 + 8'(i);
      tick();
    end
    io_in_data = 8'hEE;
    n_cmp++;
    if (io_in_rdy !== 1'b0 || rx_level !== 5'd16) begin
      n_bad++;
      $display("FAIL rx_full: rdy=%b lvl=%0d, expected 0/16", io_in_rdy, rx_level);
    end
    tick();
    io_in_vld = 1'b0;
    n_cmp++;
    if (rx_level !== 5'd16) begin
      n_bad++;
      $display("FAIL rx_full_reject: lvl=%0d, expected 16", rx_level);
    end
    wbq.push_back('{a: 6'd3, d: 32'h0000_0050});
    issue(6'h08, 32'h0, 6'd3);
    tick();
    n_cmp++;
    if (rx_level !== 5'd15 || io_in_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_pop_one: lvl=%0d rdy=%b, expected 15/1", rx_level, io_in_rdy);
    end
    wbq.push_back('{a: 6'd4, d: 32'h5453_5251});
    issue(6'h18, 32'h0, 6'd4);
    for (int i = 0; i < 4; i++) begin
      io_in_data = 8'h60 + 8'(i);
      io_in_vld = 1'b1;
      tick();
      n_cmp++;
      if (rx_level !== 5'd15) begin
        n_bad++;
        $display("FAIL rx_push_pop: step %0d lvl=%0d, expected 15", i, rx_level);
      end
    end
    io_in_vld = 1'b0;
    n_cmp++;
    if (io_busy !== 1'b0 || reg_addr !== 6'd4) begin
      n_bad++;
      $display("FAIL rx_word_done: busy=%b addr=%0d, expected 0/4", io_busy, reg_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    issue(6'h18, 32'h0, 6'd9);
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({reg_addr, reg_dd_val, io_busy, io_in_rdy, io_out_vld, io_out_data, rx_level} !==
        {6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_op: addr=%0d val=%08h busy=%b irdy=%b ovld=%b odata=%02h lvl=%0d, expected 0/0/0/1/0/00/0",
               reg_addr, reg_dd_val, io_busy, io_in_rdy, io_out_vld, io_out_data, rx_level);
    end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (io_busy !== 1'b0 || reg_addr !== 6'd0 || wbq.size() != 0 || txq.size() != 0) begin
      n_bad++;
      $display("FAIL reset_no_wb: busy=%b addr=%0d wbq=%0d txq=%0d, expected 0/0/0/0",
               io_busy, reg_addr, wbq.size(), txq.size());
    end
  endtask

  initial begin
    test_reset();
    test_out_byte();
    test_in_word();
    test_in_stall();
    test_tx_full();
    test_rx_full();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
